// File: rtl/cmos_dvp_pattern_source.sv
// -----------------------------------------------------------------------------
// cmos_dvp_pattern_source
//
// Camera-side DVP transmitter that stands in for an OV7725-style sensor.
// Produces an 8-bit vsync/href/data stream with fully parameterized frame
// timing and one of four deterministic test patterns, selected per frame.
//
// Frame layout (one line = IMG_HDISP + H_BLANK clocks):
//   VSYNC  : VSYNC_LINES lines, vsync high
//   VBACK  : V_BACK_LINES blank lines
//   ACTIVE : IMG_VDISP lines, href high for the first IMG_HDISP clocks
//   VFRONT : V_FRONT_LINES blank lines, frame_done on the very last clock
// All line-count parameters and H_BLANK are expected to be >= 1.
//
// Ports:
//   clk          in   pixel clock, all logic on the rising edge
//   rst          in   synchronous reset, active-high
//   enable       in   stream frames; only looked at on frame boundaries
//   pattern_sel  in   [1:0] pattern for the next frame, latched as vsync rises
//   cmos_vsync   out  frame sync (high = sync / invalid)
//   cmos_href    out  high while cmos_data carries an active pixel
//   cmos_data    out  [7:0] pixel value, 0 whenever href is low
//   frame_done   out  one-cycle pulse on the last clock of every frame
//   frame_cnt    out  [7:0] completed-frame counter, wraps 255 -> 0
//   busy         out  high whenever a frame is in progress
// -----------------------------------------------------------------------------
module cmos_dvp_pattern_source #(
   parameter int IMG_HDISP     = 640,
   parameter int IMG_VDISP     = 480,
   parameter int H_BLANK       = 144,
   parameter int VSYNC_LINES   = 4,
   parameter int V_BACK_LINES  = 18,
   parameter int V_FRONT_LINES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       cmos_vsync,
   output logic       cmos_href,
   output logic [7:0] cmos_data,
   output logic       frame_done,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   // ------------------------------------------------------------------
   // Geometry
   // ------------------------------------------------------------------
   localparam int LT = IMG_HDISP + H_BLANK;
   localparam int HW = (LT > 1) ? $clog2(LT) : 1;

   localparam int MAX_A = (VSYNC_LINES > V_BACK_LINES) ? VSYNC_LINES : V_BACK_LINES;
   localparam int MAX_B = (IMG_VDISP > V_FRONT_LINES) ? IMG_VDISP : V_FRONT_LINES;
   localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int LW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

   localparam logic [HW-1:0] H_LAST      = HW'(LT - 1);
   localparam logic [HW-1:0] H_ACT_END   = HW'(IMG_HDISP);
   localparam logic [LW-1:0] VSYNC_LAST  = LW'(VSYNC_LINES - 1);
   localparam logic [LW-1:0] VBACK_LAST  = LW'(V_BACK_LINES - 1);
   localparam logic [LW-1:0] ACTIVE_LAST = LW'(IMG_VDISP - 1);
   localparam logic [LW-1:0] VFRONT_LAST = LW'(V_FRONT_LINES - 1);

   // ------------------------------------------------------------------
   // FSM encoding
   // ------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_VSYNC  = 3'd1;
   localparam logic [2:0] ST_VBACK  = 3'd2;
   localparam logic [2:0] ST_ACTIVE = 3'd3;
   localparam logic [2:0] ST_VFRONT = 3'd4;

   // ------------------------------------------------------------------
   // State. The position registers (state/h_cnt/line_cnt) always describe
   // the cycle currently visible on the output pins: outputs are computed
   // from the *next* position and registered at the same edge, so every
   // output lines up with the position that produced it.
   // ------------------------------------------------------------------
   logic [2:0]    state_reg,    state_next;
   logic [HW-1:0] h_cnt_reg,    h_cnt_next;
   logic [LW-1:0] line_cnt_reg, line_cnt_next;
   logic [1:0]    sel_reg,      sel_next;
   logic [7:0]    frame_cnt_reg, frame_cnt_next;

   logic       vsync_reg, vsync_next;
   logic       href_reg,  href_next;
   logic [7:0] data_reg,  data_next;
   logic       done_reg,  done_next;
   logic       busy_reg,  busy_next;

   logic h_last;
   logic line_last;
   logic start_frame;

   // ------------------------------------------------------------------
   // End-of-line / end-of-state detection
   // ------------------------------------------------------------------
   always_comb begin
      h_last    = (h_cnt_reg == H_LAST);
      line_last = 1'b0;
      case (state_reg)
         ST_VSYNC:  line_last = (line_cnt_reg == VSYNC_LAST);
         ST_VBACK:  line_last = (line_cnt_reg == VBACK_LAST);
         ST_ACTIVE: line_last = (line_cnt_reg == ACTIVE_LAST);
         ST_VFRONT: line_last = (line_cnt_reg == VFRONT_LAST);
         default:   line_last = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Next-position logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      h_cnt_next    = h_cnt_reg;
      line_cnt_next = line_cnt_reg;
      sel_next      = sel_reg;
      start_frame   = 1'b0;

      if (state_reg == ST_IDLE) begin
         start_frame = enable;
      end else if (!h_last) begin
         h_cnt_next = h_cnt_reg + HW'(1);
      end else begin
         h_cnt_next = '0;
         if (!line_last) begin
            line_cnt_next = line_cnt_reg + LW'(1);
         end else begin
            // line_cnt restarts in every state, so within ACTIVE it is
            // directly the active row index.
            line_cnt_next = '0;
            case (state_reg)
               ST_VSYNC:  state_next = ST_VBACK;
               ST_VBACK:  state_next = ST_ACTIVE;
               ST_ACTIVE: state_next = ST_VFRONT;
               ST_VFRONT: begin
                  // Back-to-back frames: no idle gap when enable stays high.
                  if (enable) begin
                     start_frame = 1'b1;
                  end else begin
                     state_next = ST_IDLE;
                  end
               end
               default:   state_next = ST_IDLE;
            endcase
         end
      end

      // A new frame always starts at the first vsync clock; the pattern is
      // frozen here so mid-frame changes of pattern_sel are ignored.
      if (start_frame) begin
         state_next    = ST_VSYNC;
         h_cnt_next    = '0;
         line_cnt_next = '0;
         sel_next      = pattern_sel;
      end
   end

   // ------------------------------------------------------------------
   // Pattern generation (from the next position)
   // ------------------------------------------------------------------
   logic [7:0] x8;
   logic [7:0] y8;
   logic [7:0] checker_data;
   logic [7:0] pattern_data;

   generate
      if (HW >= 8) begin : g_x_wide
         assign x8 = h_cnt_next[7:0];
      end else begin : g_x_narrow
         assign x8 = {{(8 - HW){1'b0}}, h_cnt_next};
      end

      if (LW >= 8) begin : g_y_wide
         assign y8 = line_cnt_next[7:0];
      end else begin : g_y_narrow
         assign y8 = {{(8 - LW){1'b0}}, line_cnt_next};
      end
   endgenerate

   // 8x8 checkerboard: every bit of the pixel follows the same tile parity.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_checker
         assign checker_data[gi] = x8[3] ^ y8[3];
      end
   endgenerate

   always_comb begin
      pattern_data = 8'h00;
      case (sel_next)
         2'd0:    pattern_data = x8;
         2'd1:    pattern_data = y8;
         2'd2:    pattern_data = checker_data;
         default: pattern_data = x8 + y8 + frame_cnt_reg;
      endcase
   end

   // ------------------------------------------------------------------
   // Registered output values
   // ------------------------------------------------------------------
   always_comb begin
      vsync_next = (state_next == ST_VSYNC);
      href_next  = (state_next == ST_ACTIVE) && (h_cnt_next < H_ACT_END);
      data_next  = href_next ? pattern_data : 8'h00;
      done_next  = (state_next == ST_VFRONT) && (h_cnt_next == H_LAST) &&
                   (line_cnt_next == VFRONT_LAST);
      busy_next  = (state_next != ST_IDLE);
      // The counter already shows the new value during the frame_done pulse.
      frame_cnt_next = frame_cnt_reg + {7'd0, done_next};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         h_cnt_reg     <= '0;
         line_cnt_reg  <= '0;
         sel_reg       <= 2'd0;
         frame_cnt_reg <= 8'd0;
         vsync_reg     <= 1'b0;
         href_reg      <= 1'b0;
         data_reg      <= 8'h00;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         h_cnt_reg     <= h_cnt_next;
         line_cnt_reg  <= line_cnt_next;
         sel_reg       <= sel_next;
         frame_cnt_reg <= frame_cnt_next;
         vsync_reg     <= vsync_next;
         href_reg      <= href_next;
         data_reg      <= data_next;
         done_reg      <= done_next;
         busy_reg      <= busy_next;
      end
   end

   assign cmos_vsync = vsync_reg;
   assign cmos_href  = href_reg;
   assign cmos_data  = data_reg;
   assign frame_done = done_reg;
   assign frame_cnt  = frame_cnt_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_cmos_dvp_pattern_source.sv
// -----------------------------------------------------------------------------
// tb_cmos_dvp_pattern_source
//
// Two instances with small geometries: "a" (8x4 active, 96-clock frames) for
// timing, pattern switching, reset and counter wrap; "b" (16x16 active,
// 400-clock frames) for the checkerboard. A frame-position model compares
// every output of both instances on every falling edge, alongside a vector
// table and hand-written sequences for the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_cmos_dvp_pattern_source;

   // geometry of instance a
   localparam int A_HD = 8,  A_HB = 4, A_VD = 4,  A_VS = 1, A_VB = 2, A_VF = 1;
   localparam int A_FT = (A_VS + A_VB + A_VD + A_VF) * (A_HD + A_HB);
   // geometry of instance b
   localparam int B_HD = 16, B_HB = 4, B_VD = 16, B_VS = 1, B_VB = 2, B_VF = 1;
   localparam int B_FT = (B_VS + B_VB + B_VD + B_VF) * (B_HD + B_HB);

   typedef struct packed {
      logic       vsync;
      logic       href;
      logic [7:0] data;
      logic       fd;
      logic [7:0] fc;
      logic       busy;
   } out_t;

   typedef struct {
      int         off;   // clocks after the vsync rise
      logic       en;    // inputs applied after the comparison
      logic [1:0] sel;
      logic       vs;    // expected outputs
      logic       hr;
      logic [7:0] d;
      logic       fd;
      logic [7:0] fc;
   } vec_t;

   logic       clk;
   logic       rst_a, en_a, rst_b, en_b;
   logic [1:0] sel_a, sel_b;
   logic       a_vsync, a_href, a_fd, a_busy;
   logic [7:0] a_data, a_fc;
   logic       b_vsync, b_href, b_fd, b_busy;
   logic [7:0] b_data, b_fc;
   out_t       got_a, got_b;

   int checks   = 0;
   int failures = 0;

   cmos_dvp_pattern_source #(
      .IMG_HDISP(A_HD), .IMG_VDISP(A_VD), .H_BLANK(A_HB),
      .VSYNC_LINES(A_VS), .V_BACK_LINES(A_VB), .V_FRONT_LINES(A_VF)
   ) dut_a (
      .clk(clk), .rst(rst_a), .enable(en_a), .pattern_sel(sel_a),
      .cmos_vsync(a_vsync), .cmos_href(a_href), .cmos_data(a_data),
      .frame_done(a_fd), .frame_cnt(a_fc), .busy(a_busy)
   );

   cmos_dvp_pattern_source #(
      .IMG_HDISP(B_HD), .IMG_VDISP(B_VD), .H_BLANK(B_HB),
      .VSYNC_LINES(B_VS), .V_BACK_LINES(B_VB), .V_FRONT_LINES(B_VF)
   ) dut_b (
      .clk(clk), .rst(rst_b), .enable(en_b), .pattern_sel(sel_b),
      .cmos_vsync(b_vsync), .cmos_href(b_href), .cmos_data(b_data),
      .frame_done(b_fd), .frame_cnt(b_fc), .busy(b_busy)
   );

   assign got_a = {a_vsync, a_href, a_data, a_fd, a_fc, a_busy};
   assign got_b = {b_vsync, b_href, b_data, b_fd, b_fc, b_busy};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: a frame is a plain cycle index t in 0..FT-1, from
   // which line, column and active row follow by division.
   // ------------------------------------------------------------------
   function automatic out_t model_out(input int hd, hb, vd, vs, vb, vf,
                                      input bit act, input int t, fc, sel);
      out_t o;
      int lt, line, h, r, d, ft;
      o    = '0;
      o.fc = fc[7:0];
      if (!act) return o;
      lt   = hd + hb;
      ft   = (vs + vb + vd + vf) * lt;
      line = t / lt;
      h    = t % lt;
      r    = line - (vs + vb);
      o.busy  = 1'b1;
      o.vsync = (line < vs);
      o.fd    = (t == ft - 1);
      if (r >= 0 && r < vd && h < hd) begin
         o.href = 1'b1;
         case (sel)
            0:       d = h;
            1:       d = r;
            2:       d = (((h >> 3) ^ (r >> 3)) & 1) ? 255 : 0;
            default: d = h + r + fc;
         endcase
         o.data = d[7:0];
      end
      return o;
   endfunction

   task automatic model_step(input int ft, input logic rst, en, input int psel,
                             inout bit act, inout int t, inout int fc, inout int sel);
      if (rst) begin
         act = 0; t = 0; fc = 0; sel = 0;
      end else if (!act) begin
         if (en) begin act = 1; t = 0; sel = psel; end
      end else if (t == ft - 1) begin
         if (en) begin t = 0; sel = psel; end
         else act = 0;
      end else begin
         t = t + 1;
         if (t == ft - 1) fc = (fc + 1) % 256;
      end
   endtask

   bit ma_act = 0, mb_act = 0;
   int ma_t = 0, ma_fc = 0, ma_sel = 0;
   int mb_t = 0, mb_fc = 0, mb_sel = 0;

   always @(posedge clk) model_step(A_FT, rst_a, en_a, int'(sel_a), ma_act, ma_t, ma_fc, ma_sel);
   always @(posedge clk) model_step(B_FT, rst_b, en_b, int'(sel_b), mb_act, mb_t, mb_fc, mb_sel);

   always @(negedge clk) begin
      chk($sformatf("model_a t=%0d", ma_t), 32'(got_a),
          32'(model_out(A_HD, A_HB, A_VD, A_VS, A_VB, A_VF, ma_act, ma_t, ma_fc, ma_sel)));
      chk($sformatf("model_b t=%0d", mb_t), 32'(got_b),
          32'(model_out(B_HD, B_HB, B_VD, B_VS, B_VB, B_VF, mb_act, mb_t, mb_fc, mb_sel)));
   end

   // ------------------------------------------------------------------
   // Directed sequences and randomized phase
   // ------------------------------------------------------------------
   vec_t tbl[17];
   out_t exp_o;
   bit   ok;
   int   off, n, first, cnt;
   logic [7:0] fc_saved;

   initial begin
      rst_a = 1; rst_b = 1; en_a = 0; en_b = 0; sel_a = 0; sel_b = 0;

      //          off  en sel vs hr data  fd fc
      tbl[0]  = '{  0, 1, 0, 1, 0, 8'h00, 0, 8'd0};
      tbl[1]  = '{ 11, 1, 0, 1, 0, 8'h00, 0, 8'd0};
      tbl[2]  = '{ 12, 1, 0, 0, 0, 8'h00, 0, 8'd0};
      tbl[3]  = '{ 35, 1, 0, 0, 0, 8'h00, 0, 8'd0};
      tbl[4]  = '{ 36, 1, 0, 0, 1, 8'h00, 0, 8'd0};
      tbl[5]  = '{ 43, 1, 0, 0, 1, 8'h07, 0, 8'd0};
      tbl[6]  = '{ 44, 1, 0, 0, 0, 8'h00, 0, 8'd0};
      tbl[7]  = '{ 50, 1, 1, 0, 1, 8'h02, 0, 8'd0};
      tbl[8]  = '{ 79, 1, 1, 0, 1, 8'h07, 0, 8'd0};
      tbl[9]  = '{ 84, 1, 1, 0, 0, 8'h00, 0, 8'd0};
      tbl[10] = '{ 95, 1, 1, 0, 0, 8'h00, 1, 8'd1};
      tbl[11] = '{ 96, 1, 1, 1, 0, 8'h00, 0, 8'd1};
      tbl[12] = '{132, 1, 1, 0, 1, 8'h00, 0, 8'd1};
      tbl[13] = '{140, 1, 1, 0, 0, 8'h00, 0, 8'd1};
      tbl[14] = '{147, 1, 1, 0, 1, 8'h01, 0, 8'd1};
      tbl[15] = '{175, 1, 1, 0, 1, 8'h03, 0, 8'd1};
      tbl[16] = '{191, 1, 1, 0, 0, 8'h00, 1, 8'd2};

      repeat (3) @(posedge clk);
      #2;
      rst_a = 0; rst_b = 0;
      @(negedge clk);
      chk("reset_a", 32'(got_a), 32'd0);
      chk("reset_b", 32'(got_b), 32'd0);

      // Horizontal ramp, then vertical ramp from the second frame on
      en_a = 1; sel_a = 0;
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (a_vsync) ok = 1;
      end
      chk("vsync_rise_a", 32'(ok), 32'd1);
      off = 0;
      for (int i = 0; i < 17; i++) begin
         while (off < tbl[i].off) begin
            @(negedge clk);
            off++;
         end
         exp_o = '{vsync: tbl[i].vs, href: tbl[i].hr, data: tbl[i].d,
                   fd: tbl[i].fd, fc: tbl[i].fc, busy: 1'b1};
         chk($sformatf("tbl[%0d] off=%0d", i, tbl[i].off), 32'(got_a), 32'(exp_o));
         en_a = tbl[i].en; sel_a = tbl[i].sel;
      end

      // Pattern/enable changes mid-ACTIVE only take effect next frame
      sel_a = 0;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (a_href) ok = 1;
      end
      chk("href_seen_mid", 32'(ok), 32'd1);
      chk("ramp_x0", 32'(a_data), 32'd0);
      sel_a = 3; en_a = 0;
      @(negedge clk);
      chk("ramp_x1_kept", 32'(a_data), 32'd1);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (a_fd) ok = 1;
      end
      chk("done_after_drop", 32'(ok), 32'd1);
      chk("fc_after_drop", 32'(a_fc), 32'd3);
      @(negedge clk);
      chk("idle_after_drop", 32'({a_busy, a_vsync, a_href}), 32'd0);
      repeat (5) @(negedge clk);
      chk("idle_stays", 32'(a_busy), 32'd0);
      fc_saved = a_fc;
      en_a = 1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (a_href) ok = 1;
      end
      chk("href_seen_p3", 32'(ok), 32'd1);
      chk("diag_x0", 32'(a_data), 32'(fc_saved));
      @(negedge clk);
      chk("diag_x1", 32'(a_data), 32'(fc_saved + 8'd1));

      // Reset in the middle of VBACK
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (a_busy && !a_vsync && !a_href) ok = 1;
      end
      chk("blank_seen", 32'(ok), 32'd1);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (a_vsync) ok = 1;
      end
      chk("vsync_seen_rst", 32'(ok), 32'd1);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!a_vsync) ok = 1;
      end
      chk("vback_entered", 32'(ok), 32'd1);
      repeat (2) @(negedge clk);
      rst_a = 1;
      @(negedge clk);
      chk("rst_mid_vback", 32'(got_a), 32'd0);
      rst_a = 0;
      @(negedge clk);
      chk("restart_after_rst", 32'({a_vsync, a_busy, a_fc}), 32'({1'b1, 1'b1, 8'd0}));

      // 256 frames: counter wrap on the 256th frame_done
      n = 0; first = 0;
      for (int c = 0; c < 260 * A_FT && n < 256; c++) begin
         @(negedge clk);
         if (a_fd) begin
            n++;
            if (n == 1) first = c;
            if (n == 2) chk("frame_period", 32'(c - first), 32'(A_FT));
            if (n == 255) chk("fc_255", 32'(a_fc), 32'd255);
            if (n == 256) chk("fc_wrap", 32'(a_fc), 32'd0);
         end
      end
      chk("frames_256", 32'(n), 32'd256);
      en_a = 0;

      // Checkerboard on the 16x16 instance
      en_b = 1; sel_b = 2;
      ok = 0;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (b_vsync) ok = 1;
      end
      chk("vsync_rise_b", 32'(ok), 32'd1);
      en_b = 0;
      cnt = 0;
      for (int t = 0; t < B_FT; t++) begin
         if (t > 0) @(negedge clk);
         if (b_href) cnt++;
         if (t == 60)  chk("chk_r0_x0", 32'(b_data), 32'h00);
         if (t == 68)  chk("chk_r0_x8", 32'(b_data), 32'hFF);
         if (t == 220) chk("chk_r8_x0", 32'(b_data), 32'hFF);
         if (t == 228) chk("chk_r8_x8", 32'(b_data), 32'h00);
      end
      chk("href_count_b", 32'(cnt), 32'd256);

      // Randomized inputs on both instances, judged by the model
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #2;
         sel_a = 2'($urandom_range(0, 3));
         sel_b = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) en_a = ~en_a;
         if ($urandom_range(0, 199) == 0) en_b = ~en_b;
         rst_a = ($urandom_range(0, 699) == 0);
         rst_b = 1'b0;
      end
      @(posedge clk);
      #2;
      rst_a = 0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
